fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter INST_W, default 16, meaning the instruction word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 16, meaning the PC and instruction-memory address width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning the queue entry count; legal values are powers of two, 2 to 16.
REQ-004 The module SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 The module SHALL have parameter PC_STEP, default 2, meaning the byte increment between sequential fetches.
REQ-006 The module SHALL have parameter HALT_OP, default 4'hF, meaning the opcode in inst[INST_W-1:INST_W-4] that halts fetch.
REQ-007 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-008 Port: rst  in  1  reset; synchronous, active-high.
REQ-009 Port: imem_req  out  1  fetch request valid.
REQ-010 Port: imem_addr  out  ADDR_W  fetch address, valid while imem_req is high.
REQ-011 Port: imem_gnt  in  1  request accepted this cycle when imem_req is also high.
REQ-012 Port: imem_rvalid  in  1  response valid.
REQ-013 Port: imem_rdata  in  INST_W  response instruction.
REQ-014 Port: redirect  in  1  branch or flush request.
REQ-015 Port: redirect_pc  in  ADDR_W  new fetch address.
REQ-016 Port: out_valid  out  1  head entry valid.
REQ-017 Port: out_ready  in  1  consumer (IF/ID stage) accepts the head entry.
REQ-018 Port: out_inst  out  INST_W  head instruction.
REQ-019 Port: out_pc  out  ADDR_W  head entry PC.
REQ-020 Port: halted  out  1  fetch stopped on HALT_OP.

Function
REQ-021 The queue SHALL be a FIFO of {pc, inst} pairs; a dequeue SHALL occur when out_valid and out_ready are both high.
REQ-022 At most one request SHALL be outstanding; a request is outstanding from the grant cycle until imem_rvalid.
REQ-023 imem_req SHALL be high only when state is RUN, no request is outstanding, and count is less than DEPTH.
REQ-024 When a request is granted, fetch_pc SHALL advance by PC_STEP and wrap modulo 2^ADDR_W.
REQ-025 A response SHALL enqueue {pc of the granted request, imem_rdata}; the entry SHALL be visible on out_* the following cycle (non-bypass).
REQ-026 Enqueue and dequeue in the same cycle SHALL leave count unchanged.
REQ-027 The state machine SHALL have the states RUN and HALT: RUN goes to HALT on enqueue of an entry whose opcode equals HALT_OP; HALT goes to RUN only on redirect; halted is high while in HALT.
REQ-028 In HALT, queued entries, including the halt instruction, SHALL continue to drain normally.
REQ-029 On redirect, the module SHALL empty the queue and set fetch_pc to redirect_pc.
REQ-030 On redirect, the state SHALL become RUN, and any outstanding response SHALL be discarded when it arrives (kill flag).
REQ-031 On redirect, imem_req SHALL be low in that cycle, and out_valid SHALL be low in the following cycle.
REQ-032 Redirect SHALL take priority over simultaneous enqueue, dequeue, grant and halt detection.
REQ-033 While the kill flag is set, no new request SHALL issue; the flag SHALL clear on the discarded response.
REQ-034 imem_rvalid with no outstanding request SHALL be ignored.

Reset
REQ-035 On rst: count=0, out_valid=0, imem_req=0, halted=0, state=RUN, fetch_pc=RESET_PC, outstanding=0, kill=0.
REQ-036 On rst, out_inst and out_pc SHALL be 0.
REQ-037 Reset SHALL override redirect and any in-flight response; a response arriving in the reset cycle SHALL be dropped.

Configuration
REQ-038 Macro FETCH_QUEUE_BYPASS_EN: when defined, a response arriving while the queue is empty and out_ready is high SHALL appear combinationally on out_*, with out_valid high that cycle, and SHALL NOT be enqueued.
REQ-039 When FETCH_QUEUE_BYPASS_EN is not defined, every response SHALL go through the queue, giving a minimum of 1 cycle from imem_rvalid to out_valid.

Verification
REQ-040 Reset then a 1-cycle-latency memory with gnt tied high and out_ready=1 -> addresses 0,2,4,6 issued; out_pc 0,2,4,6 in order with the matching instructions.
REQ-041 out_ready=0 with DEPTH=4 -> exactly 4 entries filled; imem_req low afterwards; no entry lost or duplicated once out_ready returns to 1.
REQ-042 Redirect to 16'h0040 while a request is outstanding -> the stale response is dropped; the next out_pc is 16'h0040; count=0 in the redirect+1 cycle.
REQ-043 Instruction 16'hF000 fetched at pc 16'h000A -> halted=1; no requests after the halt enqueue; the queue drains through pc 16'h000A; redirect to 16'h0000 resumes fetch and clears halted.
REQ-044 fetch_pc=16'hFFFE when granted -> next imem_addr is 16'h0000.
REQ-045 Redirect asserted in the same cycle as rst -> fetch_pc=RESET_PC; with FETCH_QUEUE_BYPASS_EN defined, an empty queue with out_ready=1 gives zero-cycle response-to-out_valid.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one-outstanding-request fetcher feeding a {pc, inst} FIFO.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to out_* when the queue is empty.
module fetch_queue #(
    parameter int                INST_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 2,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL  = (PTR_W + 1)'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] req_pc_reg;
    logic              outstanding_reg;
    logic              kill_reg;
    logic [PTR_W:0]    count_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic grant;
    logic rsp_take;
    logic rsp_halt;
    logic bypass;
    logic enq;
    logic deq;
    logic q_valid;

    assign q_valid   = (count_reg != '0);
    assign imem_req  = !rst && !redirect && (state_reg == RUN) && !outstanding_reg
                       && !kill_reg && (count_reg < FULL);
    assign imem_addr = fetch_pc_reg;
    assign grant     = imem_req && imem_gnt;

    // A response counts only for a live (non-killed) request and never in a flush or reset cycle.
    assign rsp_take  = imem_rvalid && outstanding_reg && !kill_reg && !redirect && !rst;
    assign rsp_halt  = rsp_take && (imem_rdata[INST_W-1 -: 4] == HALT_OP);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_take && !q_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign enq       = rsp_take && !bypass;
    assign deq       = q_valid && out_ready;
    assign out_valid = q_valid || bypass;
    assign halted    = (state_reg == HALT);

    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        if (bypass) begin
            out_inst = imem_rdata;
            out_pc   = req_pc_reg;
        end else if (q_valid) begin
            out_inst = inst_mem[rd_ptr_reg];
            out_pc   = pc_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            req_pc_reg      <= '0;
            outstanding_reg <= 1'b0;
            kill_reg        <= 1'b0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else if (redirect) begin
            state_reg    <= RUN;
            fetch_pc_reg <= redirect_pc;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            // A response landing in the redirect cycle is itself the stale one, so no kill is needed.
            outstanding_reg <= outstanding_reg && !imem_rvalid;
            kill_reg        <= outstanding_reg && !imem_rvalid;
        end else begin
            if (grant) begin
                outstanding_reg <= 1'b1;
                req_pc_reg      <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + ADDR_W'(PC_STEP);
            end else if (imem_rvalid && outstanding_reg) begin
                outstanding_reg <= 1'b0;
                kill_reg        <= 1'b0;
            end
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (rsp_halt) begin
                state_reg <= HALT;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                    inst_mem[gi] <= imem_rdata;
                    pc_mem[gi]   <= req_pc_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory responder, scoreboard of granted fetches,
// an address-vector table and hand sequences for stall, redirect and halt.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic        halted;

    always #5 clk = ~clk;

    fetch_queue #(
        .INST_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000), .PC_STEP(2), .HALT_OP(4'hF)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .halted(halted)
    );

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP_EXP = 1'b1;
`else
    localparam logic BYP_EXP = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory responder with programmable latency; the halt opcode appears at one address.
    int          mem_lat   = 1;
    logic        halt_on   = 1'b0;
    logic [15:0] halt_addr = 16'h000A;
    logic        pend      = 1'b0;
    int          wait_cnt  = 0;
    logic [15:0] pend_addr = 16'h0000;
    logic        force_rv  = 1'b0;

    function automatic logic [15:0] inst_of(input logic [15:0] a, input logic h_on,
                                            input logic [15:0] h_addr);
        if (h_on && a == h_addr) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (imem_req && imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
            wait_cnt  <= mem_lat - 1;
        end else if (pend) begin
            if (wait_cnt == 0) pend <= 1'b0;
            else wait_cnt <= wait_cnt - 1;
        end
    end

    assign imem_rvalid = force_rv || (pend && wait_cnt == 0);
    assign imem_rdata  = (halt_on && pend_addr == halt_addr) ? 16'hF000 : {4'h1, pend_addr[11:0]};

    // Scoreboard: a grant pushes the expected entry, a dequeue pops and compares.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } entry_t;

    entry_t      sb[$];
    entry_t      mon_e;
    logic [15:0] grant_log[$];
    logic [15:0] deq_log[$];
    logic        tb_out     = 1'b0;
    logic        prev_redir = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            tb_out     = 1'b0;
            prev_redir = 1'b0;
        end else begin
            if (prev_redir) check("valid_after_redirect", out_valid, 0);
            prev_redir = redirect;
            if (redirect) begin
                check("req_in_redirect", imem_req, 0);
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_deq: actual pc=%h required no entry", out_pc);
                    end else begin
                        mon_e = sb.pop_front();
                        check("deq_pc", out_pc, mon_e.pc);
                        check("deq_inst", out_inst, mon_e.inst);
                        deq_log.push_back(out_pc);
                        $display("deq pc=%h inst=%h", out_pc, out_inst);
                    end
                end
                if (imem_req && imem_gnt) begin
                    sb.push_back({imem_addr, inst_of(imem_addr, halt_on, halt_addr)});
                    grant_log.push_back(imem_addr);
                end
            end
            if (imem_req && (tb_out || halted)) check("req_while_busy", imem_req, 0);
            if (imem_req && imem_gnt) tb_out = 1'b1;
            else if (imem_rvalid) tb_out = 1'b0;
        end
    end

    typedef struct {
        logic [15:0] rpc;
        logic [15:0] exp_first;
        logic [15:0] exp_next;
    } addr_vec_t;

    addr_vec_t   vecs[4];
    logic [15:0] exp_a[4];
    int          n0;

    initial begin
        vecs[0] = '{rpc: 16'h0040, exp_first: 16'h0040, exp_next: 16'h0042};
        vecs[1] = '{rpc: 16'hFFFE, exp_first: 16'hFFFE, exp_next: 16'h0000};
        vecs[2] = '{rpc: 16'h1230, exp_first: 16'h1230, exp_next: 16'h1232};
        vecs[3] = '{rpc: 16'h7FFE, exp_first: 16'h7FFE, exp_next: 16'h8000};
        exp_a = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};

        // Reset with redirect held and a stray response in the reset cycle.
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        imem_gnt = 1'b0; out_ready = 1'b0;
        tick(2);
        force_rv = 1'b1;
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        tick();
        rst = 1'b0; redirect = 1'b0; force_rv = 1'b0;
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_inst", out_inst, 0);
        check("reset_pc_out", out_pc, 0);
        check("reset_halted", halted, 0);
        check("reset_req", imem_req, 1);
        check("reset_fetch_pc", imem_addr, 16'h0000);

        // Streaming with 1-cycle memory; check response-to-out_valid latency on an empty queue.
        grant_log.delete();
        deq_log.delete();
        tick();
        imem_gnt = 1'b1; out_ready = 1'b1; mem_lat = 1;
        @(negedge clk);
        @(negedge clk);
        check("rsp_cycle_rvalid", imem_rvalid, 1);
        check("rsp_cycle_out_valid", out_valid, BYP_EXP);
        tick();
        for (int i = 0; i < 40 && deq_log.size() < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            check("stream_addr", grant_log[i], exp_a[i]);
            check("stream_out_pc", deq_log[i], exp_a[i]);
        end

        // Consumer stall fills the queue exactly, then drains without loss.
        out_ready = 1'b0;
        tick(20);
        @(negedge clk);
        check("full_req_low", imem_req, 0);
        check("full_valid", out_valid, 1);
        tick();
        check("full_entries", sb.size(), 4);
        out_ready = 1'b1;
        tick(10);
        imem_gnt = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 0);
        @(negedge clk);
        check("drain_valid", out_valid, 0);
        tick();

        // Redirect targets, including PC wrap at the top of the address space.
        for (int v = 0; v < 4; v++) begin
            imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = vecs[v].rpc;
            tick();
            redirect = 1'b0;
            @(negedge clk);
            check("vec_first_addr", imem_addr, vecs[v].exp_first);
            check("vec_first_req", imem_req, 1);
            tick();
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (imem_req) break;
            end
            check("vec_next_req", imem_req, 1);
            check("vec_next_addr", imem_addr, vecs[v].exp_next);
            tick();
        end

        // Redirect while a slow request is outstanding: the stale response must vanish.
        mem_lat = 3; imem_gnt = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) break;
        end
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        n0 = deq_log.size();
        tick();
        redirect = 1'b0; mem_lat = 1;
        @(negedge clk);
        check("redirect_count_zero", out_valid, 0);
        tick();
        for (int i = 0; i < 30 && deq_log.size() <= n0; i++) tick();
        check("redirect_deq_seen", deq_log.size() > n0, 1);
        check("redirect_first_pc", deq_log[n0], 16'h0040);

        // Halt on opcode F at 0x000A with a bursty consumer, drain, then resume.
        halt_on = 1'b1; halt_addr = 16'h000A;
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 80 && !halted; i++) begin
            out_ready = (i % 3 == 0);
            tick();
        end
        check("halt_seen", halted, 1);
        n0 = grant_log.size();
        out_ready = 1'b1;
        tick(10);
        check("halt_no_req", grant_log.size(), n0);
        check("halt_last_grant", grant_log[grant_log.size() - 1], 16'h000A);
        check("halt_last_deq", deq_log[deq_log.size() - 1], 16'h000A);
        @(negedge clk);
        check("halt_drained", out_valid, 0);
        check("halt_held", halted, 1);
        tick();
        halt_on = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("resume_halted", halted, 0);
        check("resume_req", imem_req, 1);
        check("resume_addr", imem_addr, 16'h0000);
        tick();
        imem_gnt = 1'b0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
